// File: rtl/seq_tx_101011_if.sv
// Control/serial bundle between a 101011 frame transmitter and its controller.
// SEQ_TX_ERR_INJ_EN adds the err_inj request line.
interface seq_tx_101011_if #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             stop;
  logic             x;
  logic             x_vld;
  logic             sof;
  logic             busy;
  logic             done;
`ifdef SEQ_TX_ERR_INJ_EN
  logic             err_inj;
`endif

  modport master (
`ifdef SEQ_TX_ERR_INJ_EN
    output err_inj,
`endif
    output start, reps, gap, stop,
    input  x, x_vld, sof, busy, done
  );

  modport slave (
`ifdef SEQ_TX_ERR_INJ_EN
    input  err_inj,
`endif
    input  start, reps, gap, stop,
    output x, x_vld, sof, busy, done
  );
endinterface

// File: rtl/seq_tx_101011.sv
// Serial 101011 frame transmitter, MSB first: single, repeated or continuous frames with idle gap.
// Define SEQ_TX_ERR_INJ_EN to add err_inj, which inverts the last bit of the next frame.
module seq_tx_101011 #(
  parameter int unsigned      PAT_W   = 6,
  parameter logic [PAT_W-1:0] PATTERN = 6'b101011,
  parameter int unsigned      CNT_W   = 4,
  parameter int unsigned      GAP_W   = 4
) (
  input logic            clk,
  input logic            rst,
  seq_tx_101011_if.slave bus
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [GAP_W-1:0] gap_rld_q, gap_rld_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             corrupt;

`ifdef SEQ_TX_ERR_INJ_EN
  logic corrupt_q, corrupt_d;
  assign corrupt = corrupt_q;
`else
  assign corrupt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      frm_cnt_q   <= '0;
      gap_rld_q   <= '0;
      gap_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
`ifdef SEQ_TX_ERR_INJ_EN
      corrupt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frm_cnt_q   <= frm_cnt_d;
      gap_rld_q   <= gap_rld_d;
      gap_cnt_q   <= gap_cnt_d;
      stop_pend_q <= stop_pend_d;
`ifdef SEQ_TX_ERR_INJ_EN
      corrupt_q   <= corrupt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frm_cnt_d   = frm_cnt_q;
    gap_rld_d   = gap_rld_q;
    gap_cnt_d   = gap_cnt_q;
    stop_pend_d = stop_pend_q;
`ifdef SEQ_TX_ERR_INJ_EN
    corrupt_d   = corrupt_q;
`endif
    unique case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        if (bus.start) begin
          state_d   = StSend;
          idx_d     = IDX_LAST;
          frm_cnt_d = bus.reps;
          gap_rld_d = bus.gap;
          gap_cnt_d = '0;
`ifdef SEQ_TX_ERR_INJ_EN
          corrupt_d = bus.err_inj;
`endif
        end
      end
      StSend: begin
        // A stop never truncates a frame; it is held until the last bit.
        if (bus.stop) stop_pend_d = 1'b1;
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else begin
`ifdef SEQ_TX_ERR_INJ_EN
          corrupt_d = bus.err_inj;
`endif
          if (frm_cnt_q != '0) frm_cnt_d = frm_cnt_q - CNT_W'(1);
          // frm_cnt_q == 0 means continuous mode, so only a count of 1 ends the run.
          if (frm_cnt_q == CNT_W'(1) || stop_pend_q || bus.stop) begin
            state_d = StDone;
          end else if (gap_rld_q == '0) begin
            idx_d = IDX_LAST;
          end else begin
            state_d   = StGap;
            gap_cnt_d = gap_rld_q;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (bus.stop) begin
          state_d = StDone;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = StSend;
          idx_d   = IDX_LAST;
        end
      end
      StDone: begin
        state_d     = StIdle;
        stop_pend_d = 1'b0;
        frm_cnt_d   = '0;
        gap_cnt_d   = '0;
`ifdef SEQ_TX_ERR_INJ_EN
        corrupt_d   = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.x     = 1'b0;
    bus.x_vld = 1'b0;
    bus.sof   = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    unique case (state_q)
      StSend: begin
        bus.x     = PATTERN[idx_q] ^ (corrupt && (idx_q == '0));
        bus.x_vld = 1'b1;
        bus.sof   = (idx_q == IDX_LAST);
        bus.busy  = 1'b1;
      end
      StGap:   bus.busy = 1'b1;
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_tx_101011.sv
// Directed bench for seq_tx_101011: expected {sof,x} per frame bit queued at launch,
// checked against the bits captured by a negedge monitor.
module tb_seq_tx_101011;

  localparam int unsigned PAT_W = 6;
  localparam logic [PAT_W-1:0] PAT = 6'b101011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_tx_101011_if #(.CNT_W(4), .GAP_W(4)) bus ();

  seq_tx_101011 #(
    .PAT_W  (PAT_W),
    .PATTERN(PAT),
    .CNT_W  (4),
    .GAP_W  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int failed = 0;
  int rd = 0;
  logic [1:0] exp_q[$];

  // Monitor-owned state; the stimulus process only reads it.
  int cyc = 0;
  int sof_cnt = 0, busy_cnt = 0, done_cnt = 0, vld_cnt = 0, z_cnt = 0, obs_n = 0;
  logic [5:0] z_sh = '0;
  logic obs_x [512];
  logic obs_sof [512];

  int b_sof, b_busy, b_done, b_vld, b_z;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sof === 1'b1) sof_cnt <= sof_cnt + 1;
    if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.x_vld === 1'b1) vld_cnt <= vld_cnt + 1;
    if ({z_sh[4:0], bus.x} === PAT) z_cnt <= z_cnt + 1;
    z_sh <= {z_sh[4:0], bus.x};
    if (bus.x_vld === 1'b1 && obs_n < 512) begin
      obs_x[obs_n]   <= bus.x;
      obs_sof[obs_n] <= bus.sof;
      obs_n          <= obs_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic snap();
    b_sof  = sof_cnt;
    b_busy = busy_cnt;
    b_done = done_cnt;
    b_vld  = vld_cnt;
    b_z    = z_cnt;
  endtask

  task automatic push_bits(input int n, input bit corrupt);
    for (int i = 0; i < n; i++) begin
      int k;
      k = PAT_W - 1 - i;
      exp_q.push_back({(k == PAT_W - 1), PAT[k] ^ (corrupt && k == 0)});
    end
  endtask

  // Returns at the first negedge after the launch edge, with c0 = cycle of that edge.
  task automatic launch(input logic [3:0] r, input logic [3:0] g, input logic s, output int c0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.reps  = r;
    bus.gap   = g;
    bus.stop  = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int c0, input int budget, output int t);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    t = cyc - c0 + 1;
    tests++;
    assert (bus.done === 1'b1) else begin
      failed++;
      $error("FAIL done_timeout observed %b expected 1", bus.done);
    end
  endtask

  task automatic finish_run(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_busy_after"}, 32'(bus.busy), 0);
    chk({tag, "_done_after"}, 32'(bus.done), 0);
  endtask

  task automatic drain(input string tag);
    logic [1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (rd < obs_n) begin
        assert ({obs_sof[rd], obs_x[rd]} === e) else begin
          failed++;
          $error("FAIL %s_bit%0d observed sof,x=%b%b expected %b", tag, rd, obs_sof[rd],
                 obs_x[rd], e);
        end
        rd++;
      end else begin
        failed++;
        $error("FAIL %s_missing observed none expected sof,x=%b", tag, e);
      end
    end
    chk({tag, "_extra_bits"}, obs_n - rd, 0);
    rd = obs_n;
  endtask

  initial begin
    int c0, t;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.reps  = '0;
    bus.gap   = '0;
`ifdef SEQ_TX_ERR_INJ_EN
    bus.err_inj = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_x", 32'(bus.x), 0);
    chk("reset_x_vld", 32'(bus.x_vld), 0);
    chk("reset_sof", 32'(bus.sof), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    rst = 1'b0;
    #1;

    // Reset during bit 3 of a continuous run: abandon, no done pulse.
    snap();
    push_bits(3, 1'b0);
    launch(4'd0, 4'd0, 1'b0, c0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_x", 32'(bus.x), 0);
    chk("midrst_x_vld", 32'(bus.x_vld), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("midrst_no_done", done_cnt - b_done, 0);
    chk("midrst_vld", vld_cnt - b_vld, 3);
    chk("midrst_idle_busy", 32'(bus.busy), 0);
    drain("midrst");

    // Single frame.
    snap();
    push_bits(6, 1'b0);
    launch(4'd1, 4'd0, 1'b0, c0);
    wait_done(c0, 40, t);
    chk("single_done_cycle", t, 7);
    finish_run("single");
    chk("single_sof", sof_cnt - b_sof, 1);
    chk("single_busy", busy_cnt - b_busy, 6);
    chk("single_done_cnt", done_cnt - b_done, 1);
    chk("single_z", z_cnt - b_z, 1);
    drain("single");

    // Three frames with a 2-cycle gap.
    snap();
    push_bits(6, 1'b0);
    push_bits(6, 1'b0);
    push_bits(6, 1'b0);
    launch(4'd3, 4'd2, 1'b0, c0);
    wait_done(c0, 60, t);
    chk("reps_done_cycle", t, 23);
    finish_run("reps");
    chk("reps_busy", busy_cnt - b_busy, 22);
    chk("reps_vld", vld_cnt - b_vld, 18);
    chk("reps_sof", sof_cnt - b_sof, 3);
    chk("reps_z", z_cnt - b_z, 3);
    chk("reps_done_cnt", done_cnt - b_done, 1);
    drain("reps");

    // Continuous, stop during bit 3 of frame 2: frame 2 still completes.
    snap();
    push_bits(6, 1'b0);
    push_bits(6, 1'b0);
    launch(4'd0, 4'd0, 1'b0, c0);
    repeat (8) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    wait_done(c0, 40, t);
    chk("cstop_done_cycle", t, 13);
    finish_run("cstop");
    chk("cstop_vld", vld_cnt - b_vld, 12);
    chk("cstop_z", z_cnt - b_z, 2);
    chk("cstop_done_cnt", done_cnt - b_done, 1);
    drain("cstop");

    // Continuous with gap=3, stop in the gap: DONE at the next edge.
    snap();
    push_bits(6, 1'b0);
    launch(4'd0, 4'd3, 1'b0, c0);
    repeat (6) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    wait_done(c0, 40, t);
    chk("gstop_done_cycle", t, 8);
    finish_run("gstop");
    chk("gstop_vld", vld_cnt - b_vld, 6);
    chk("gstop_busy", busy_cnt - b_busy, 7);
    drain("gstop");

    // start while busy is ignored; reps/gap are not resampled.
    snap();
    push_bits(6, 1'b0);
    push_bits(6, 1'b0);
    launch(4'd2, 4'd1, 1'b0, c0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.reps  = 4'd5;
    bus.gap   = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(c0, 60, t);
    chk("ign_done_cycle", t, 14);
    finish_run("ign");
    chk("ign_busy", busy_cnt - b_busy, 13);
    chk("ign_sof", sof_cnt - b_sof, 2);
    chk("ign_done_cnt", done_cnt - b_done, 1);
    drain("ign");

    // stop together with start in IDLE is ignored.
    snap();
    push_bits(6, 1'b0);
    launch(4'd1, 4'd0, 1'b1, c0);
    wait_done(c0, 40, t);
    chk("idlestop_done_cycle", t, 7);
    finish_run("idlestop");
    chk("idlestop_vld", vld_cnt - b_vld, 6);
    drain("idlestop");

`ifdef SEQ_TX_ERR_INJ_EN
    // Corrupt frame 1 only.
    snap();
    push_bits(6, 1'b1);
    push_bits(6, 1'b0);
    bus.err_inj = 1'b1;
    launch(4'd2, 4'd0, 1'b0, c0);
    bus.err_inj = 1'b0;
    wait_done(c0, 40, t);
    chk("inj_done_cycle", t, 13);
    finish_run("inj");
    chk("inj_z", z_cnt - b_z, 1);
    drain("inj");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
